// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame state type and line-level constants
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_bit_counter.sv
// rtl/uart_bit_counter.sv - terminal-count counter with clear/enable and last flag
module uart_bit_counter #(
  parameter int WIDTH    = 3,
  parameter int TERMINAL = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

  assign last = (count == TERM);

  // Wraps to zero on the terminal cycle so the count is already clean on exit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit framing FSM driving an external shift register
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 slow_baud_clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  input  logic                 data_bit,
  output logic                 load,
  output logic                 shift,
  output logic                 tx_line,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(DATA_BITS);

  uart_state_t      state;
  logic             parity_acc;
  logic [CNT_W-1:0] bit_cnt;
  logic             data_last;
  logic [0:0]       stop_cnt;
  logic             stop_last;
  logic             unused_sig;

  // tx_data is captured by the external shift register through load.
  assign unused_sig = ^{tx_data, bit_cnt, stop_cnt};

  assign load    = (state == ST_IDLE) && tx_start;
  assign shift   = (state == ST_DATA);
  assign tx_busy = (state != ST_IDLE);

  uart_bit_counter #(
    .WIDTH   (CNT_W),
    .TERMINAL(DATA_BITS - 1)
  ) u_data_cnt (
    .clk   (slow_baud_clk),
    .reset (reset),
    .clear (state != ST_DATA),
    .enable(state == ST_DATA),
    .count (bit_cnt),
    .last  (data_last)
  );

  uart_bit_counter #(
    .WIDTH   (1),
    .TERMINAL(STOP_BITS - 1)
  ) u_stop_cnt (
    .clk   (slow_baud_clk),
    .reset (reset),
    .clear (state != ST_STOP),
    .enable(state == ST_STOP),
    .count (stop_cnt),
    .last  (stop_last)
  );

  // tx_line always carries the previous cycle's bit, giving one guard cycle after STOP.
  always_ff @(posedge slow_baud_clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      tx_line    <= LINE_IDLE;
      tx_done    <= 1'b0;
      parity_acc <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_line <= LINE_IDLE;
          if (tx_start) begin
            state      <= ST_START;
            parity_acc <= 1'b0;
          end
        end
        ST_START: begin
          tx_line <= START_BIT;
          state   <= ST_DATA;
        end
        ST_DATA: begin
          tx_line    <= data_bit;
          parity_acc <= parity_acc ^ data_bit;
          if (data_last) begin
            state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          tx_line <= parity_acc ^ (PARITY_ODD != 0);
          state   <= ST_STOP;
        end
        ST_STOP: begin
          tx_line <= LINE_IDLE;
          if (stop_last) begin
            state   <= ST_IDLE;
            tx_done <= 1'b1;
          end
        end
        default: begin
          tx_line <= LINE_IDLE;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - randomized frame-level checks of uart_tx_ctrl across three configurations
module tb_uart_tx_ctrl;

  localparam int N = 2048;
  localparam int DB[3] = '{8, 6, 5};
  localparam int PE[3] = '{1, 1, 0};
  localparam int PO[3] = '{0, 1, 0};
  localparam int SB[3] = '{1, 2, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic       load_w[3];
  logic       shift_w[3];
  logic       line_w[3];
  logic       busy_w[3];
  logic       done_w[3];
  logic       dbit_w[3];
  logic [7:0] sr[3] = '{8'h00, 8'h00, 8'h00};

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int next_free[3];

  logic exp_line[3][N];
  logic exp_busy[3][N];
  logic exp_done[3][N];
  logic exp_load[3][N];
  logic exp_shift[3][N];

  always #5 clk = ~clk;

  uart_tx_ctrl u_a (
    .slow_baud_clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .data_bit(dbit_w[0]), .load(load_w[0]), .shift(shift_w[0]), .tx_line(line_w[0]),
    .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );

  uart_tx_ctrl #(.DATA_BITS(6), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_b (
    .slow_baud_clk(clk), .reset(reset), .tx_data(tx_data[5:0]), .tx_start(tx_start),
    .data_bit(dbit_w[1]), .load(load_w[1]), .shift(shift_w[1]), .tx_line(line_w[1]),
    .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );

  uart_tx_ctrl #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_c (
    .slow_baud_clk(clk), .reset(reset), .tx_data(tx_data[4:0]), .tx_start(tx_start),
    .data_bit(dbit_w[2]), .load(load_w[2]), .shift(shift_w[2]), .tx_line(line_w[2]),
    .tx_busy(busy_w[2]), .tx_done(done_w[2])
  );

  // External transmit shift registers, one per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (load_w[i]) sr[i] <= tx_data;
      else if (shift_w[i]) sr[i] <= sr[i] >> 1;
    end
  end

  assign dbit_w[0] = sr[0][0];
  assign dbit_w[1] = sr[1][0];
  assign dbit_w[2] = sr[2][0];

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_model(input int from);
    for (int i = 0; i < 3; i++) begin
      for (int k = from; k < N; k++) begin
        exp_line[i][k]  = 1'b1;
        exp_busy[i][k]  = 1'b0;
        exp_done[i][k]  = 1'b0;
        exp_load[i][k]  = 1'b0;
        exp_shift[i][k] = 1'b0;
      end
      next_free[i] = from;
    end
  endtask

  // Frame accepted at the edge ending cycle c: bits appear on the line from cycle c+2.
  task automatic schedule(input int i, input int c, input logic [7:0] d);
    logic       q[$];
    logic [7:0] mask;
    int         len;
    int         ones;
    mask = 8'((1 << DB[i]) - 1);
    ones = $countones(d & mask);
    q.push_back(1'b0);
    for (int j = 0; j < DB[i]; j++) q.push_back(d[j]);
    if (PE[i] != 0) q.push_back(((ones + PO[i]) % 2) != 0);
    for (int s = 0; s < SB[i]; s++) q.push_back(1'b1);
    len = q.size();
    exp_load[i][c] = 1'b1;
    for (int k = 1; k <= len; k++) exp_busy[i][c + k] = 1'b1;
    for (int j = 0; j < len; j++) exp_line[i][c + 2 + j] = q[j];
    for (int k = 2; k <= 1 + DB[i]; k++) exp_shift[i][c + k] = 1'b1;
    exp_done[i][c + 1 + len] = 1'b1;
    next_free[i] = c + 1 + len;
  endtask

  task automatic step(input logic st, input logic [7:0] d);
    tx_start = st;
    tx_data  = d;
    if (st && reset) begin
      for (int i = 0; i < 3; i++) begin
        if (cyc >= next_free[i]) schedule(i, cyc, d);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_bit($sformatf("u%0d.tx_line", i), line_w[i], exp_line[i][cyc]);
      check_bit($sformatf("u%0d.tx_busy", i), busy_w[i], exp_busy[i][cyc]);
      check_bit($sformatf("u%0d.tx_done", i), done_w[i], exp_done[i][cyc]);
      check_bit($sformatf("u%0d.load", i), load_w[i], exp_load[i][cyc]);
      check_bit($sformatf("u%0d.shift", i), shift_w[i], exp_shift[i][cyc]);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic pulse_reset();
    tx_start = 1'b0;
    reset    = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_bit($sformatf("u%0d.rst_line", i), line_w[i], 1'b1);
      check_bit($sformatf("u%0d.rst_busy", i), busy_w[i], 1'b0);
    end
    clear_model(cyc);
    step(1'b0, 8'($urandom));
    #2;
    reset = 1'b1;
  endtask

  initial begin
    bit hold;
    clear_model(0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step(1'b0, 8'($urandom));
    #2 reset = 1'b1;
    repeat (20) step(1'b0, 8'($urandom));

    step(1'b1, 8'hA5);
    repeat (16) step(1'b0, 8'($urandom));
    step(1'b1, 8'h07);
    repeat (16) step(1'b0, 8'($urandom));

    repeat (26) step(1'b1, 8'h3C);
    repeat (16) step(1'b0, 8'($urandom));

    step(1'b1, 8'h5A);
    repeat (4) step(1'b0, 8'($urandom));
    step(1'b1, 8'hFF);
    repeat (14) step(1'b0, 8'($urandom));

    step(1'b1, 8'hC3);
    repeat (5) step(1'b0, 8'($urandom));
    pulse_reset();
    repeat (20) step(1'b0, 8'($urandom));

    hold = 1'b0;
    for (int n = 0; n < 1200; n++) begin
      if (n % 60 == 0) hold = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else step(hold || ($urandom_range(0, 4) == 0), 8'($urandom));
    end
    repeat (16) step(1'b0, 8'($urandom));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Transmit-side framing controller for the UART. It accepts a byte-wide request from the host and drives `load`/`shift` into the transmit shift register. It takes that register's LSB (`data_bit`) back and produces the framed serial line: start bit, data LSB-first, optional parity, and stop bit(s). It runs entirely in the baud domain, one clock edge per bit period.

## Interface
- `DATA_BITS`, 8: data bits per frame. Legal values are 5–8. `tx_data` is this wide.
- `PARITY_EN`, 1: 1 inserts a parity bit after the data; 0 omits it.
- `PARITY_ODD`, 0: 0 selects even parity; 1 selects odd.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `slow_baud_clk` in 1: baud-rate clock. Each rising edge is one bit period.
- `reset` in 1: asynchronous, active-low reset.
- `tx_data` in DATA_BITS: host byte. Sampled only on the accepting edge.
- `tx_start` in 1: transmit request. Level-sampled in IDLE only.
- `data_bit` in 1: current LSB of the transmit shift register.
- `load` out 1: parallel load strobe to the shift register (combinational).
- `shift` out 1: right-shift enable to the shift register (combinational).
- `tx_line` out 1: serial output. Registered; idles high.
- `tx_busy` out 1: high while the frame FSM is not IDLE.
- `tx_done` out 1: one-cycle pulse. Registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Transitions:
  - IDLE→START when `tx_start`=1.
  - START→DATA unconditionally.
  - DATA→PARITY (or →STOP if `PARITY_EN`=0) after DATA_BITS cycles.
  - PARITY→STOP unconditionally.
  - STOP→IDLE after STOP_BITS cycles.
- `load` = (IDLE & `tx_start`). The shift register captures `tx_data` on the same edge the FSM leaves IDLE.
- `shift` = (state==DATA). START holds the register, so `data_bit` = d0 on entry to DATA.
- Bit counter: $clog2(DATA_BITS) bits. Cleared on entry to DATA, increments per DATA cycle, returns to 0 on exit. A separate 1-bit stop counter serves STOP.
- Parity accumulator: cleared on the accepting edge; XORs `data_bit` in every DATA cycle. The transmitted parity bit is acc ^ `PARITY_ODD`.
- Line select for cycle k, registered into `tx_line` at edge k+1:
  - IDLE→1
  - START→0
  - DATA→`data_bit`
  - PARITY→parity
  - STOP→1
- `tx_done` is registered high for exactly one cycle after STOP→IDLE, i.e. while the last stop bit is on the line.
- `tx_busy` = (state != IDLE), combinational.
- `tx_start` while busy is ignored; there is no queuing. `tx_data` changes after acceptance have no effect.
- Reset values (asynchronous, immediate): state IDLE, `tx_line`=1, `tx_done`=0, counters 0, accumulator 0. Consequently `load`=`shift`=`tx_busy`=0.
- Reset mid-frame aborts the frame. Line returns high with no partial stop bit. The next frame requires a fresh `tx_start` after reset release.

## Timing
Defaults (8 data bits, parity on, 1 stop bit), with accept edge = edge 0:
- FSM state by cycle:
  - cycle 1: START
  - cycles 2–9: DATA d0..d7
  - cycle 10: PARITY
  - cycle 11: STOP
  - cycle 12: IDLE
- `tx_line` by cycle:
  - cycle 1: 1
  - cycle 2: start bit 0
  - cycles 3–10: d0..d7
  - cycle 11: parity
  - cycle 12: stop bit 1
- `tx_busy` is high in cycles 1–11. `tx_done` is high in cycle 12.
- Latency from `tx_start` edge to start bit on the line: 2 cycles.
- Frame length on the line: 1 + DATA_BITS + PARITY_EN + STOP_BITS cycles.
- Back-to-back: with `tx_start` held high, the next frame is accepted in cycle 12. The line stays high for cycles 12–13 (stop bit plus one guard cycle), and the next start bit appears in cycle 14.
- `STOP_BITS`=2 adds one STOP cycle. `tx_done` moves out by one cycle.

## Structure
- Shared package `uart_pkg`:
  - FSM state type: 3-bit encoding, IDLE=0.
  - Constants LINE_IDLE=1'b1 and START_BIT=1'b0, shared with the future RX block.
- One sub-module: `uart_bit_counter`.
  - Parameterised terminal-count counter with clear/enable and a `last` flag.
  - Instantiated twice, for data and stop counting. RX will reuse it.
- The shift register stays external. This block only drives its `load`/`shift` and reads `data_bit`.

## Test plan
- Reset release, no request → `tx_line`=1, `tx_busy`=0, `load`=`shift`=0 for 20 cycles.
- `tx_data`=0xA5, even parity, pulse `tx_start` → line from cycle 2: 0,1,0,1,0,0,1,0,1,0(parity),1. `tx_done` high in cycle 12 only.
- Same with `PARITY_ODD`=1 and `tx_data`=0x07 → parity bit 0. With even parity the bit is 1.
- `tx_start` held high for two frames of 0x3C → second start bit in cycle 14. `load` pulses exactly at edges 0 and 12.
- Pulse `tx_start` again in cycle 5 → ignored; the frame is unchanged and `load` does not pulse.
- Assert `reset` low in cycle 6 → `tx_line`=1 and `tx_busy`=0 immediately. After release there is no activity until a new `tx_start`.
